ioctl_word_loader: RTL and testbench
====================================

IOCTL_WORD_LOADER -- requirements
Module: ioctl_word_loader

Interface
REQ-001 Parameters: DATA_W (default 16, meaning SDRAM word width, 16 or 32); ADDR_W (default 25, meaning byte address width); NUM_REGIONS (default 4, meaning header region count, 1-8); FIFO_DEPTH (default 4, meaning buffered words, power of 2, minimum 2).
REQ-002 clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ioctl_downl  in  1  download active; ioctl_wr  in  1  byte strobe; ioctl_data  in  8  byte value.
REQ-005 ioctl_wait  out  1  backpressure; no byte is accepted while high.
REQ-006 sdr_addr  out  ADDR_W  byte address, word-aligned; sdr_data  out  DATA_W  write data; sdr_be  out  DATA_W/8  byte enables.
REQ-007 sdr_req  out  1  toggle handshake request; sdr_ack  in  1  request is complete when sdr_ack equals sdr_req.
REQ-008 region_base  out  NUM_REGIONS*ADDR_W  flattened region start addresses; region_idx  out  3  current payload region.
REQ-009 loaded  out  1  image fully written; overflow  out  1  payload exceeded header total; checksum  out  16  payload byte sum.

Function
REQ-010 The FSM SHALL have states IDLE, HEADER, PAYLOAD, FLUSH and DONE.
REQ-011 IDLE -> HEADER on a rising edge of ioctl_downl; the byte counter, FIFO, overflow and checksum SHALL clear at that transition.
REQ-012 HEADER SHALL capture 2*NUM_REGIONS bytes as big-endian 16-bit region sizes in 64 KiB units, then enter PAYLOAD.
REQ-013 region_base[0] SHALL be 0; region_base[i] SHALL equal region_base[i-1] + size[i-1]*65536, truncated to ADDR_W.
REQ-014 PAYLOAD bytes SHALL be packed little-endian: byte offset n goes to lane n mod (DATA_W/8) of the word at address n rounded down to a word boundary.
REQ-015 A full word SHALL be pushed to the FIFO on the cycle after its last lane is written, with sdr_be all ones.
REQ-016 region_idx SHALL increment when the byte offset reaches the next region_base, saturating at NUM_REGIONS-1.
REQ-017 Bytes at offsets at or beyond the header total SHALL be dropped and SHALL set overflow, which stays set until the next download starts.
REQ-018 ioctl_wait SHALL be high when the FIFO holds FIFO_DEPTH-1 or more words, or while in FLUSH.
REQ-019 The FIFO head SHALL be issued by toggling sdr_req, with sdr_addr, sdr_data and sdr_be stable until the acknowledge arrives; one request SHALL be outstanding at most.
REQ-020 The FIFO head SHALL pop on the cycle sdr_ack==sdr_req is seen; the next request may toggle on that same cycle.
REQ-021 A push and a pop in the same cycle SHALL leave the FIFO count unchanged; a push into a full FIFO SHALL NOT occur.
REQ-022 A falling edge of ioctl_downl in HEADER or PAYLOAD SHALL enter FLUSH; any partial word SHALL be pushed, with sdr_be set only for the written lanes.
REQ-023 FLUSH -> DONE when the FIFO is empty and no request is outstanding; loaded SHALL rise on entry to DONE.
REQ-024 Ending the download in HEADER SHALL set overflow and leave every unreceived size at 0.
REQ-025 In DONE, a new rising edge of ioctl_downl SHALL clear loaded and enter HEADER.

Reset
REQ-026 Reset SHALL force IDLE, empty the FIFO and clear loaded, overflow, checksum, region_idx, region sizes, sdr_addr, sdr_data, sdr_be and ioctl_wait to 0.
REQ-027 On reset, sdr_req SHALL load the current sdr_ack, so that no request is pending.
REQ-028 Reset asserted mid-transfer SHALL abandon the transfer; no further toggle of sdr_req occurs until new payload words exist.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined, checksum SHALL hold the 16-bit wrapping sum of all accepted, non-dropped payload bytes.
REQ-030 Without LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder is synthesised.

Verification
REQ-031 DATA_W=16, NUM_REGIONS=2, header 00 01 00 02 -> region_base = {0x00000, 0x10000}; 0x30000 payload bytes produce 0x18000 requests; loaded=1 and overflow=0 at the end.
REQ-032 DATA_W=32, payload bytes 11 22 33 44 55, then ioctl_downl falls -> two requests: addr 0 with data 0x44332211 and be 1111, then addr 4 with data 0x00000055 and be 0001.
REQ-033 sdr_ack withheld for 100 cycles with a continuous byte stream -> ioctl_wait rises at FIFO count FIFO_DEPTH-1, and no bytes are lost or duplicated after release.
REQ-034 Header total of 64 KiB followed by 65537 bytes -> overflow=1, the last byte is not written, and loaded=1.
REQ-035 Reset pulsed for 1 cycle mid-PAYLOAD with one request outstanding -> sdr_req==sdr_ack on the next cycle, state is IDLE, and loaded=0.
REQ-036 LOADER_CHECKSUM_EN defined, payload of 0x200 bytes of 0xFF -> checksum=0xFE00; with the macro undefined -> checksum=0.

Source files
------------

// File: rtl/ioctl_word_loader.sv
// ioctl_word_loader
//   Receives a byte-serial download (ioctl_*), decodes a header of
//   NUM_REGIONS big-endian 16-bit region sizes (64 KiB units), then packs the
//   payload little-endian into DATA_W-bit words and writes them to SDRAM
//   through a small FIFO and a toggle request/acknowledge handshake.
//
// Ports
//   clk_sys, reset       : clock, synchronous active-high reset
//   ioctl_downl/wr/data  : download active, byte strobe, byte value
//   ioctl_wait           : backpressure; no byte is taken while high
//   sdr_addr/data/be     : word-aligned byte address, write data, byte enables
//   sdr_req / sdr_ack    : toggle handshake; done when sdr_ack == sdr_req
//   region_base          : flattened region start addresses (region 0 in LSBs)
//   region_idx           : region of the current payload offset
//   loaded / overflow    : image written / payload exceeded header total
//   checksum             : 16-bit wrapping sum of written payload bytes
//
// Configuration
//   LOADER_CHECKSUM_EN   : when defined, checksum is accumulated; otherwise it
//                          is tied to 0 and no adder exists.

// One byte lane of the word assembly buffer. A write wins over a clear so a
// new word can start on the same cycle the previous one is pushed.
module ioctl_word_loader_lane (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       wr,
  input  logic       clr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       vld
);
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (wr) begin
      data_d = din;
      vld_d  = 1'b1;
    end else if (clr) begin
      data_d = 8'h00;
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_q <= 8'h00;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign dout = data_q;
  assign vld  = vld_q;
endmodule

module ioctl_word_loader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 25,
  parameter int NUM_REGIONS = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ioctl_downl,
  input  logic                          ioctl_wr,
  input  logic [7:0]                    ioctl_data,
  output logic                          ioctl_wait,
  output logic [ADDR_W-1:0]             sdr_addr,
  output logic [DATA_W-1:0]             sdr_data,
  output logic [DATA_W/8-1:0]           sdr_be,
  output logic                          sdr_req,
  input  logic                          sdr_ack,
  output logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  output logic [2:0]                    region_idx,
  output logic                          loaded,
  output logic                          overflow,
  output logic [15:0]                   checksum
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int OFF_W = 36;  // holds 8 regions * 65535 * 64 KiB without wrap
  localparam int HC_W  = 4;

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  be;
  } ent_t;

  state_t                             state_q, state_d;
  logic                               downl_q, downl_d;
  logic [HC_W-1:0]                    hdr_cnt_q, hdr_cnt_d;
  logic [NUM_REGIONS-1:0][15:0]       size_q, size_d;
  logic [OFF_W-1:0]                   off_q, off_d;
  logic [ADDR_W-1:0]                  wrd_addr_q, wrd_addr_d;
  logic                               push_full_q, push_full_d;
  ent_t [FIFO_DEPTH-1:0]              fifo_q, fifo_d;
  logic [PW-1:0]                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                      count_q, count_d;
  logic                               out_q, out_d;
  logic                               sdr_req_q, sdr_req_d;
  logic [ADDR_W-1:0]                  sdr_addr_q, sdr_addr_d;
  logic [DATA_W-1:0]                  sdr_data_q, sdr_data_d;
  logic [LANES-1:0]                   sdr_be_q, sdr_be_d;
  logic [2:0]                         region_idx_q, region_idx_d;
  logic                               loaded_q, loaded_d;
  logic                               overflow_q, overflow_d;

  logic                               rise, fall, acc, start, pay_wr;
  logic                               push, push_part, done, issue;
  logic [PW-1:0]                      head;
  logic [NUM_REGIONS-1:0][OFF_W-1:0]  base_full;
  logic [OFF_W-1:0]                   total;
  logic [2:0]                         region_cnt;
  logic [LB-1:0]                      lane_sel;
  logic [LANES-1:0][7:0]              lane_q;
  logic [LANES-1:0]                   lane_vld, lane_wr;
  logic                               lane_clr;

  assign rise     = ioctl_downl & ~downl_q;
  assign fall     = ~ioctl_downl & downl_q;
  assign acc      = ioctl_wr & ioctl_downl & ~ioctl_wait &
                    ((state_q == HEADER) | (state_q == PAYLOAD));
  assign lane_sel = off_q[LB-1:0];
  assign lane_clr = push | start;

  // Region bases are a running sum of the sizes; the final sum is the
  // header total that payload offsets are checked against.
  always_comb begin
    total = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base_full[i] = total;
      total        = total + OFF_W'({size_q[i], 16'h0000});
    end
  end

  // Bases are monotonic, so the number of bases at or below the offset is
  // the index of the region holding it; empty regions are skipped naturally.
  always_comb begin
    region_cnt = 3'd0;
    for (int i = 1; i < NUM_REGIONS; i++)
      if (base_full[i] <= off_q) region_cnt = region_cnt + 3'd1;
  end

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_base
    assign region_base[i*ADDR_W +: ADDR_W] = base_full[i][ADDR_W-1:0];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_wr[g] = pay_wr & (lane_sel == LB'(g));
    ioctl_word_loader_lane u_lane (
      .clk_sys (clk_sys),
      .reset   (reset),
      .wr      (lane_wr[g]),
      .clr     (lane_clr),
      .din     (ioctl_data),
      .dout    (lane_q[g]),
      .vld     (lane_vld[g])
    );
  end

  // FSM next state, header capture and payload byte steering
  always_comb begin
    state_d      = state_q;
    downl_d      = ioctl_downl;
    hdr_cnt_d    = hdr_cnt_q;
    size_d       = size_q;
    off_d        = off_q;
    wrd_addr_d   = wrd_addr_q;
    push_full_d  = 1'b0;
    region_idx_d = region_idx_q;
    loaded_d     = loaded_q;
    overflow_d   = overflow_q;
    start        = 1'b0;
    pay_wr       = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d = HEADER;
        start   = 1'b1;
      end
      HEADER: begin
        if (fall) begin
          // short header: sizes not received stay 0
          state_d    = FLUSH;
          overflow_d = 1'b1;
        end else if (acc) begin
          for (int r = 0; r < NUM_REGIONS; r++) begin
            if (hdr_cnt_q[HC_W-1:1] == 3'(r)) begin
              if (hdr_cnt_q[0]) size_d[r][7:0]  = ioctl_data;
              else              size_d[r][15:8] = ioctl_data;
            end
          end
          hdr_cnt_d = hdr_cnt_q + HC_W'(1);
          if (hdr_cnt_q == HC_W'(2*NUM_REGIONS-1)) state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (fall) begin
          state_d = FLUSH;
        end else if (acc) begin
          if (off_q >= total) begin
            overflow_d = 1'b1;
          end else begin
            pay_wr      = 1'b1;
            off_d       = off_q + OFF_W'(1);
            wrd_addr_d  = {off_q[ADDR_W-1:LB], {LB{1'b0}}};
            push_full_d = (lane_sel == {LB{1'b1}});
          end
        end
      end
      FLUSH: begin
        if ((count_q == '0) && !out_q && !(|lane_vld) && !push_full_q) begin
          state_d  = DONE;
          loaded_d = 1'b1;
        end
      end
      DONE: if (rise) begin
        state_d = HEADER;
        start   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == PAYLOAD) || (state_q == FLUSH)) region_idx_d = region_cnt;
    if (start) begin
      hdr_cnt_d    = '0;
      size_d       = '0;
      off_d        = '0;
      overflow_d   = 1'b0;
      loaded_d     = 1'b0;
      region_idx_d = 3'd0;
    end
  end

  // FIFO and request issue. The head stays in the FIFO while its request is
  // outstanding; when it completes the next entry can be issued at once.
  assign push_part = (state_q == FLUSH) & (|lane_vld) & ~push_full_q &
                     (count_q != CW'(FIFO_DEPTH));
  assign push      = push_full_q | push_part;
  assign done      = out_q & (sdr_ack == sdr_req_q);
  assign head      = done ? rd_ptr_q + PW'(1) : rd_ptr_q;
  assign issue     = (~out_q | done) & (count_q > CW'(done));

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(done);
    out_d      = issue | (out_q & ~done);
    sdr_req_d  = issue ? ~sdr_req_q : sdr_req_q;
    sdr_addr_d = sdr_addr_q;
    sdr_data_d = sdr_data_q;
    sdr_be_d   = sdr_be_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: wrd_addr_q, data: lane_q, be: lane_vld};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (done) rd_ptr_d = rd_ptr_q + PW'(1);
    if (issue) begin
      sdr_addr_d = fifo_q[head].addr;
      sdr_data_d = fifo_q[head].data;
      sdr_be_d   = fifo_q[head].be;
    end
    if (start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      downl_q      <= 1'b0;
      hdr_cnt_q    <= '0;
      size_q       <= '0;
      off_q        <= '0;
      wrd_addr_q   <= '0;
      push_full_q  <= 1'b0;
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_q        <= 1'b0;
      sdr_req_q    <= sdr_ack;  // nothing pending after reset
      sdr_addr_q   <= '0;
      sdr_data_q   <= '0;
      sdr_be_q     <= '0;
      region_idx_q <= 3'd0;
      loaded_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      downl_q      <= downl_d;
      hdr_cnt_q    <= hdr_cnt_d;
      size_q       <= size_d;
      off_q        <= off_d;
      wrd_addr_q   <= wrd_addr_d;
      push_full_q  <= push_full_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      sdr_data_q   <= sdr_data_d;
      sdr_be_q     <= sdr_be_d;
      region_idx_q <= region_idx_d;
      loaded_q     <= loaded_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start)       csum_d = 16'h0000;
    else if (pay_wr) csum_d = csum_q + {8'h00, ioctl_data};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) csum_q <= 16'h0000;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign ioctl_wait = (count_q >= CW'(FIFO_DEPTH-1)) | (state_q == FLUSH);
  assign sdr_addr   = sdr_addr_q;
  assign sdr_data   = sdr_data_q;
  assign sdr_be     = sdr_be_q;
  assign sdr_req    = sdr_req_q;
  assign region_idx = region_idx_q;
  assign loaded     = loaded_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_ioctl_word_loader.sv
module tb_ioctl_word_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 25;
  localparam int NR     = 2;
  localparam int DEPTH  = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ioctl_downl, ioctl_wr;
  logic [7:0]           ioctl_data;
  logic                 ioctl_wait;
  logic [ADDR_W-1:0]    sdr_addr;
  logic [DATA_W-1:0]    sdr_data;
  logic [DATA_W/8-1:0]  sdr_be;
  logic                 sdr_req;
  logic                 sdr_ack = 1'b0;
  logic [NR*ADDR_W-1:0] region_base;
  logic [2:0]           region_idx;
  logic                 loaded, overflow;
  logic [15:0]          checksum;

  int n_cmp = 0;
  int n_bad = 0;
  logic ack_en = 1'b1;
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  logic [3:0]        log_be[$];

  ioctl_word_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGIONS(NR),
                      .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait), .sdr_addr(sdr_addr),
    .sdr_data(sdr_data), .sdr_be(sdr_be), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
    .region_base(region_base), .region_idx(region_idx), .loaded(loaded),
    .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // SDRAM model: logs and acknowledges a pending request half a cycle later
  always @(negedge clk) begin
    if (ack_en && !reset && (sdr_req !== sdr_ack)) begin
      log_addr.push_back(sdr_addr);
      log_data.push_back(sdr_data);
      log_be.push_back(sdr_be);
      sdr_ack = sdr_req;
    end
  end

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_be.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    ioctl_wr = 1'b1;
    ioctl_data = b;
    while (ioctl_wait && g < 1000) begin @(negedge clk); g++; end
    if (ioctl_wait) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ioctl_wait=%0b want 0", ioctl_wait);
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] h0, h1, h2, h3);
    ioctl_downl = 1'b1;
    @(negedge clk);
    send_byte(h0); send_byte(h1); send_byte(h2); send_byte(h3);
  endtask

  task automatic end_dl(input string nm);
    int g = 0;
    ioctl_wr = 1'b0;
    ioctl_downl = 1'b0;
    @(negedge clk);
    while (!loaded && g < 3000) begin @(negedge clk); g++; end
    if (!loaded) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: loaded=%0b want 1", nm, loaded);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0; ioctl_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (loaded !== 1'b0) begin n_bad++; $display("FAIL rst_loaded: got %0b want 0", loaded); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL rst_wait: got %0b want 0", ioctl_wait); end
    n_cmp++; if (sdr_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %0b want 0", sdr_req); end
    n_cmp++; if (sdr_addr !== '0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", sdr_addr); end
    n_cmp++; if (sdr_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", sdr_data); end
    n_cmp++; if (sdr_be !== '0) begin n_bad++; $display("FAIL rst_be: got %b want 0", sdr_be); end
    n_cmp++; if (region_base !== '0) begin n_bad++; $display("FAIL rst_base: got %h want 0", region_base); end
    n_cmp++; if (region_idx !== 3'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", region_idx); end
    n_cmp++; if (checksum !== 16'h0) begin n_bad++; $display("FAIL rst_csum: got %h want 0", checksum); end
  endtask

  task automatic test_region_base();
    logic [NR*ADDR_W-1:0] exp_base = {25'h0010000, 25'h0000000};
    logic [15:0] exp_cs;
    clear_log();
    start_dl(8'h00, 8'h01, 8'h00, 8'h02);
    n_cmp++; if (region_base !== exp_base) begin n_bad++; $display("FAIL rb_base: got %h want %h", region_base, exp_base); end
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    end_dl("rb");
`ifdef LOADER_CHECKSUM_EN
    exp_cs = 16'h051C;
`else
    exp_cs = 16'h0000;
`endif
    n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL rb_nreq: got %0d want 2", log_addr.size()); end
    else begin
      n_cmp++; if (log_data[0] !== 32'hA3A2A1A0 || log_addr[0] !== 0 || log_be[0] !== 4'hF) begin n_bad++;
        $display("FAIL rb_w0: got %h/%h/%b want 0/a3a2a1a0/1111", log_addr[0], log_data[0], log_be[0]); end
      n_cmp++; if (log_data[1] !== 32'hA7A6A5A4 || log_addr[1] !== 4 || log_be[1] !== 4'hF) begin n_bad++;
        $display("FAIL rb_w1: got %h/%h/%b want 4/a7a6a5a4/1111", log_addr[1], log_data[1], log_be[1]); end
    end
    n_cmp++; if (loaded !== 1'b1 || overflow !== 1'b0) begin n_bad++; $display("FAIL rb_flags: got ld=%0b ov=%0b want 1/0", loaded, overflow); end
    n_cmp++; if (region_idx !== 3'd0) begin n_bad++; $display("FAIL rb_idx: got %0d want 0", region_idx); end
    n_cmp++; if (checksum !== exp_cs) begin n_bad++; $display("FAIL rb_csum: got %h want %h", checksum, exp_cs); end
  endtask

  task automatic test_partial();
    logic [15:0] exp_cs;
    clear_log();
    ioctl_downl = 1'b1;
    @(negedge clk);
    n_cmp++; if (loaded !== 1'b0) begin n_bad++; $display("FAIL pw_loaded_clr: got %0b want 0", loaded); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    end_dl("pw");
`ifdef LOADER_CHECKSUM_EN
    exp_cs = 16'h00FF;
`else
    exp_cs = 16'h0000;
`endif
    n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL pw_nreq: got %0d want 2", log_addr.size()); end
    else begin
      n_cmp++; if (log_addr[0] !== 0 || log_data[0] !== 32'h44332211 || log_be[0] !== 4'b1111) begin n_bad++;
        $display("FAIL pw_w0: got %h/%h/%b want 0/44332211/1111", log_addr[0], log_data[0], log_be[0]); end
      n_cmp++; if (log_addr[1] !== 4 || log_data[1] !== 32'h00000055 || log_be[1] !== 4'b0001) begin n_bad++;
        $display("FAIL pw_w1: got %h/%h/%b want 4/00000055/0001", log_addr[1], log_data[1], log_be[1]); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL pw_ovf: got %0b want 0", overflow); end
    n_cmp++; if (checksum !== exp_cs) begin n_bad++; $display("FAIL pw_csum: got %h want %h", checksum, exp_cs); end
  endtask

  task automatic test_header_abort();
    logic [NR*ADDR_W-1:0] exp_base = {25'h0030000, 25'h0000000};
    clear_log();
    ioctl_downl = 1'b1;
    @(negedge clk);
    send_byte(8'h00); send_byte(8'h03);
    end_dl("ha");
    n_cmp++; if (overflow !== 1'b1 || loaded !== 1'b1) begin n_bad++; $display("FAIL ha_flags: got ov=%0b ld=%0b want 1/1", overflow, loaded); end
    n_cmp++; if (region_base !== exp_base) begin n_bad++; $display("FAIL ha_base: got %h want %h", region_base, exp_base); end
    n_cmp++; if (log_addr.size() != 0) begin n_bad++; $display("FAIL ha_nreq: got %0d want 0", log_addr.size()); end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int g = 0;
    int bad = 0;
    clear_log();
    ack_en = 1'b0;
    start_dl(8'h00, 8'h01, 8'h00, 8'h00);
    for (int c = 0; c < 100; c++) begin
      ioctl_wr = 1'b1; ioctl_data = 8'(nacc);
      if (!ioctl_wait) nacc++;
      @(negedge clk);
    end
    // three full words queued (count 3) plus the first byte of the fourth
    n_cmp++; if (nacc != 13) begin n_bad++; $display("FAIL bp_accepted: got %0d want 13", nacc); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL bp_wait: got %0b want 1", ioctl_wait); end
    ack_en = 1'b1;
    while (nacc < 40 && g < 500) begin
      ioctl_wr = 1'b1; ioctl_data = 8'(nacc);
      if (!ioctl_wait) nacc++;
      @(negedge clk); g++;
    end
    end_dl("bp");
    n_cmp++; if (log_addr.size() != 10) begin n_bad++; $display("FAIL bp_nreq: got %0d want 10", log_addr.size()); end
    else begin
      for (int k = 0; k < 10; k++)
        if (log_addr[k] !== ADDR_W'(4*k) || log_be[k] !== 4'hF ||
            log_data[k] !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_data: got %0d bad words want 0", bad); end
    end
  endtask

  task automatic test_checksum();
    logic [15:0] exp_cs;
    clear_log();
    start_dl(8'h00, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 'h200; i++) send_byte(8'hFF);
    end_dl("cs");
`ifdef LOADER_CHECKSUM_EN
    exp_cs = 16'hFE00;
`else
    exp_cs = 16'h0000;
`endif
    n_cmp++; if (checksum !== exp_cs) begin n_bad++; $display("FAIL cs_value: got %h want %h", checksum, exp_cs); end
    n_cmp++; if (log_addr.size() != 128) begin n_bad++; $display("FAIL cs_nreq: got %0d want 128", log_addr.size()); end
  endtask

  task automatic test_midreset();
    logic r0;
    int tog = 0;
    clear_log();
    ack_en = 1'b0;
    start_dl(8'h00, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    n_cmp++; if (sdr_req === sdr_ack) begin n_bad++; $display("FAIL mr_pending: got req=%0b ack=%0b want differ", sdr_req, sdr_ack); end
    reset = 1'b1; ioctl_downl = 1'b0; ioctl_wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (sdr_req !== sdr_ack) begin n_bad++; $display("FAIL mr_req: got %0b want %0b", sdr_req, sdr_ack); end
    n_cmp++; if (loaded !== 1'b0 || ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL mr_flags: got ld=%0b wt=%0b want 0/0", loaded, ioctl_wait); end
    r0 = sdr_req;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (sdr_req !== r0) tog++; end
    n_cmp++; if (tog != 0) begin n_bad++; $display("FAIL mr_toggle: got %0d toggles want 0", tog); end
    ack_en = 1'b1;
    start_dl(8'h00, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
    end_dl("mr");
    n_cmp++; if (log_addr.size() != 1 || log_data[0] !== 32'hC3C2C1C0) begin n_bad++;
      $display("FAIL mr_reload: got %0d reqs want 1 with c3c2c1c0", log_addr.size()); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_cs = 16'h0000;
    clear_log();
    start_dl(8'h00, 8'h01, 8'h00, 8'h00);
    for (int i = 0; i < 65537; i++) begin
`ifdef LOADER_CHECKSUM_EN
      if (i < 65536) exp_cs = exp_cs + 16'(i & 255);
`endif
      send_byte(8'(i));
    end
    end_dl("ov");
    n_cmp++; if (overflow !== 1'b1 || loaded !== 1'b1) begin n_bad++; $display("FAIL ov_flags: got ov=%0b ld=%0b want 1/1", overflow, loaded); end
    n_cmp++; if (log_addr.size() != 16384) begin n_bad++; $display("FAIL ov_nreq: got %0d want 16384", log_addr.size()); end
    else begin
      n_cmp++; if (log_addr[16383] !== 25'h000FFFC || log_data[16383] !== 32'hFFFEFDFC || log_be[16383] !== 4'hF) begin n_bad++;
        $display("FAIL ov_last: got %h/%h/%b want 0fffc/fffefdfc/1111", log_addr[16383], log_data[16383], log_be[16383]); end
    end
    n_cmp++; if (region_idx !== 3'd1) begin n_bad++; $display("FAIL ov_idx: got %0d want 1", region_idx); end
    n_cmp++; if (checksum !== exp_cs) begin n_bad++; $display("FAIL ov_csum: got %h want %h", checksum, exp_cs); end
  endtask

  initial begin
    test_reset();
    test_region_base();
    test_partial();
    test_header_abort();
    test_backpressure();
    test_checksum();
    test_midreset();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
